// File: rtl/relay_link.sv
// relay_link: 14443-A relay bridge between two Proxmarks and the ARM SSP (MASTER / SLAVE / DELAY modes).
// Define RELAY_LOOPBACK_EN to make mod_type 011 a MASTER self-test that loops data_out back into rx.
module relay_link #(
  parameter int                DIV_LOG2  = 4,
  parameter int                FRAME_W   = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC      = 4'hA,
  parameter int                DELAY_W   = 32,
  parameter int                HOLDOFF_W = 17
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [2:0] mod_type,
  input  logic       ssp_dout,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic       data_in,
  output logic       data_out
);
  localparam int BW = $clog2(FRAME_W);
  localparam int RW = $clog2(DELAY_W);
  localparam logic [DIV_LOG2-1:0] HALF = {1'b1, {(DIV_LOG2-1){1'b0}}};
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W-1);
  localparam logic [RW-1:0] LAST_RPT = RW'(DELAY_W-1);
  localparam logic [1:0] S_IDLE = 2'd0, S_TIMING = 2'd1, S_DONE = 2'd2;
  localparam logic [2:0] M_MASTER = 3'd0, M_SLAVE = 3'd1, M_DELAY = 3'd2;
`ifdef RELAY_LOOPBACK_EN
  localparam logic [2:0] M_LOOP = 3'd3;
  logic r_lb;
`endif
  logic [DIV_LOG2-1:0]  r_div;
  logic [2:0]           r_mode;
  logic                 r_din;
  logic [SYNC_W-1:0]    r_tx_sr;
  logic [FRAME_W-1:0]   r_rx_sr, r_out_sr;
  logic [BW-1:0]        r_bcnt;
  logic [RW-1:0]        r_rcnt;
  logic [HOLDOFF_W-1:0] r_hold;
  logic [DELAY_W-1:0]   r_delay;
  logic [1:0]           r_state, w_state_nxt;
  logic                 w_tick, w_chg, w_master, w_rx_bit, w_tx_sync, w_rx_sync, w_hdr;
  logic                 w_rpt, w_rpt_last, w_timing, w_done, w_start, w_stop;
  logic [SYNC_W-1:0]    w_tx_new;
  logic [FRAME_W-1:0]   w_rx_new;
  logic [RW-1:0]        w_ridx;
  assign w_tick = r_div == HALF;
  assign w_chg  = mod_type != r_mode;
`ifdef RELAY_LOOPBACK_EN
  assign w_master = r_mode == M_MASTER || r_mode == M_LOOP;
  assign w_rx_bit = r_mode == M_LOOP ? r_lb : r_din;
`else
  assign w_master = r_mode == M_MASTER;
  assign w_rx_bit = r_din;
`endif
  assign w_tx_new   = {r_tx_sr[SYNC_W-2:0], ssp_dout};
  assign w_rx_new   = {r_rx_sr[FRAME_W-2:0], w_rx_bit};
  assign w_tx_sync  = w_master && w_tick && !w_chg && w_tx_new == SYNC;
  assign w_rx_sync  = w_master && w_tick && !w_chg && w_rx_new[SYNC_W-1:0] == SYNC;
  assign w_hdr      = &w_rx_new[FRAME_W-1 -: SYNC_W];
  assign w_rpt      = r_mode == M_DELAY && w_done && r_hold[HOLDOFF_W-1] && w_tick && !w_chg;
  assign w_rpt_last = w_rpt && r_rcnt == LAST_RPT;
  assign w_ridx     = LAST_RPT - r_rcnt;
  always_ff @(posedge ck_1356meg) r_state <= reset ? S_IDLE : w_state_nxt;
  always_comb
    w_state_nxt = w_start ? S_TIMING : w_stop ? S_DONE : (w_done && w_rpt_last) ? S_IDLE : r_state;
  always_comb begin
    w_timing = r_state == S_TIMING;
    w_done   = r_state == S_DONE;
    w_start  = r_state == S_IDLE && w_tx_sync;
    w_stop   = w_timing && w_rx_sync;
  end
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      r_div     <= '0;
      r_mode    <= '0;
      r_din     <= 1'b0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_out_sr  <= '0;
      r_bcnt    <= '0;
      r_rcnt    <= '0;
      r_hold    <= '0;
      r_delay   <= '0;
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
      data_out  <= 1'b0;
`ifdef RELAY_LOOPBACK_EN
      r_lb      <= 1'b0;
`endif
    end else begin
      r_div   <= r_div + 1'b1;
      ssp_clk <= (r_div == '0) ? 1'b1 : w_tick ? 1'b0 : ssp_clk;
      r_din   <= data_in;
      r_mode  <= mod_type;
      // The delay count survives mode changes so DELAY can report a MASTER measurement.
      if (w_start || w_rpt_last)
        r_delay <= '0;
      else if (w_timing && !(&r_delay))
        r_delay <= r_delay + 1'b1;
      if (w_chg) begin
        r_tx_sr   <= '0;
        r_rx_sr   <= '0;
        r_out_sr  <= '0;
        r_bcnt    <= '0;
        r_rcnt    <= '0;
        r_hold    <= '0;
        ssp_frame <= 1'b0;
        ssp_din   <= 1'b0;
        data_out  <= 1'b0;
`ifdef RELAY_LOOPBACK_EN
        r_lb      <= 1'b0;
`endif
      end else begin
        if (w_tick)
          r_bcnt <= (r_bcnt == LAST_BIT) ? '0 : r_bcnt + 1'b1;
        if (w_master) begin
          if (w_tick) begin
            data_out  <= ssp_dout;
            r_tx_sr   <= w_tx_new;
            r_rx_sr   <= w_stop ? '0 : w_rx_new;
            ssp_frame <= r_bcnt == '0;
            ssp_din   <= 1'b0;
`ifdef RELAY_LOOPBACK_EN
            r_lb      <= data_out;
`endif
          end
        end else if (r_mode == M_SLAVE) begin
          if (w_tick) begin
            data_out  <= r_din;
            r_rx_sr   <= w_hdr ? '0 : w_rx_new;
            r_out_sr  <= w_hdr ? w_rx_new : r_out_sr << 1;
            ssp_frame <= w_hdr;
            ssp_din   <= r_out_sr[FRAME_W-1];
          end
        end else if (r_mode == M_DELAY) begin
          data_out <= 1'b0;
          if (!w_done || w_rpt_last)
            r_hold <= '0;
          else if (!r_hold[HOLDOFF_W-1])
            r_hold <= r_hold + 1'b1;
          if (w_rpt) begin
            r_rcnt    <= w_rpt_last ? '0 : r_rcnt + 1'b1;
            ssp_frame <= r_rcnt == '0;
            ssp_din   <= r_delay[w_ridx];
          end else if (w_tick) begin
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
          end
        end else begin
          ssp_frame <= 1'b0;
          ssp_din   <= 1'b0;
          data_out  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_relay_link.sv
// tb_relay_link: directed bench for relay_link with a 12-bit delay counter and a short holdoff.
module tb_relay_link;
  logic       clk = 1'b0, reset = 1'b1;
  logic [2:0] mod_type = 3'd0;
  logic       ssp_dout = 1'b0, data_in = 1'b0;
  logic       ssp_clk, ssp_frame, ssp_din, data_out;
  int         checks = 0, errors = 0;

  relay_link #(.DELAY_W(12), .HOLDOFF_W(6)) dut (
    .ck_1356meg(clk), .reset(reset), .mod_type(mod_type), .ssp_dout(ssp_dout),
    .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge right after the next bit_tick has updated the outputs.
  task automatic bit_step();
    int n = 0;
    while (ssp_clk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    while (ssp_clk !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL bit_step: ssp_clk stuck at %b, required toggling", ssp_clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mod_type = 3'd0; ssp_dout = 1'b0; data_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] pat, input bit on_din);
    logic [3:0] p;
    p = pat;
    for (int i = 3; i >= 0; i--) begin
      if (on_din) data_in = p[i]; else ssp_dout = p[i];
      bit_step();
    end
    ssp_dout = 1'b0; data_in = 1'b0;
  endtask

  task automatic read_report(output logic [11:0] val, output int frames);
    int n = 0;
    val = '0; frames = 0;
    while (ssp_frame !== 1'b1 && n < 12) begin bit_step(); n++; end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) bit_step();
      val = {val[10:0], ssp_din};
      frames += (ssp_frame === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ssp_clk, ssp_frame, ssp_din, data_out} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b, required 0000", {ssp_clk, ssp_frame, ssp_din, data_out});
    end
    send(4'b1010, 1'b0);
    checks++;
    if (dut.r_state !== 2'd1) begin errors++; $display("FAIL reset_pre_timing: state %0d, required 1", dut.r_state); end
    ssp_dout = 1'b1;
    bit_step();
    checks++;
    if (data_out !== 1'b1) begin errors++; $display("FAIL reset_pre_dout: data_out %b, required 1", data_out); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ssp_dout = 1'b0;
    checks++;
    if ({ssp_clk, ssp_frame, ssp_din, data_out} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got %b, required 0000", {ssp_clk, ssp_frame, ssp_din, data_out});
    end
    checks++;
    if (dut.r_state !== 2'd0 || dut.r_delay !== 12'd0) begin
      errors++; $display("FAIL reset_mid_state: state %0d delay %0d, required 0 0", dut.r_state, dut.r_delay);
    end
  endtask

  task automatic test_master_delay();
    logic [3:0]  p;
    logic [11:0] val;
    int          fr;
    do_reset();
    p = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      ssp_dout = p[i];
      bit_step();
      checks++;
      if (data_out !== p[i]) begin errors++; $display("FAIL master_dout[%0d]: got %b, required %b", i, data_out, p[i]); end
    end
    ssp_dout = 1'b0;
    checks++;
    if (dut.r_state !== 2'd1) begin errors++; $display("FAIL master_timing: state %0d, required 1", dut.r_state); end
    fr = 0;
    for (int i = 0; i < 8; i++) begin
      bit_step();
      fr += (ssp_frame === 1'b1) ? 1 : 0;
    end
    checks++;
    if (fr != 1) begin errors++; $display("FAIL master_frame: %0d frame pulses in 8 bits, required 1", fr); end
    repeat (28) bit_step();
    send(4'b1010, 1'b1);
    checks++;
    if (dut.r_state !== 2'd2) begin errors++; $display("FAIL master_done: state %0d, required 2", dut.r_state); end
    checks++;
    if (dut.r_delay < 624 || dut.r_delay > 656) begin
      errors++; $display("FAIL master_delay: delay %0d, required 640 +-16", dut.r_delay);
    end
    mod_type = 3'd2;
    @(negedge clk);
    read_report(val, fr);
    checks++;
    if (fr != 1) begin errors++; $display("FAIL report_frames: %0d, required 1", fr); end
    checks++;
    if (val < 624 || val > 656) begin errors++; $display("FAIL report_value: %0d, required 640 +-16", val); end
    checks++;
    if (dut.r_state !== 2'd0 || dut.r_delay !== 12'd0) begin
      errors++; $display("FAIL report_end: state %0d delay %0d, required 0 0", dut.r_state, dut.r_delay);
    end
    bit_step();
    checks++;
    if (ssp_frame !== 1'b0 || ssp_din !== 1'b0) begin
      errors++; $display("FAIL report_quiet: frame %b din %b, required 0 0", ssp_frame, ssp_din);
    end
  endtask

  task automatic test_timeout();
    logic [11:0] val;
    int          fr;
    do_reset();
    send(4'b1010, 1'b0);
    repeat (260) bit_step();
    checks++;
    if (dut.r_delay !== 12'hFFF || dut.r_state !== 2'd1) begin
      errors++; $display("FAIL timeout_sat: delay %h state %0d, required fff 1", dut.r_delay, dut.r_state);
    end
    send(4'b1010, 1'b1);
    checks++;
    if (dut.r_state !== 2'd2) begin errors++; $display("FAIL timeout_done: state %0d, required 2", dut.r_state); end
    mod_type = 3'd2;
    @(negedge clk);
    read_report(val, fr);
    checks++;
    if (val !== 12'hFFF || fr != 1) begin
      errors++; $display("FAIL timeout_report: value %h frames %0d, required fff 1", val, fr);
    end
  endtask

  task automatic test_slave();
    logic [7:0] p, got;
    int         fr;
    do_reset();
    mod_type = 3'd1;
    bit_step();
    p = 8'b1111_0110;
    for (int i = 7; i >= 0; i--) begin
      data_in = p[i];
      bit_step();
      checks++;
      if (ssp_frame !== (i == 0) || data_out !== p[i]) begin
        errors++; $display("FAIL slave_rx[%0d]: frame %b dout %b, required %b %b", i, ssp_frame, data_out, i == 0, p[i]);
      end
    end
    data_in = 1'b0;
    got = '0; fr = 0;
    for (int i = 0; i < 8; i++) begin
      bit_step();
      got = {got[6:0], ssp_din};
      fr += (ssp_frame === 1'b1) ? 1 : 0;
    end
    checks++;
    if (got !== 8'hF6 || fr != 0) begin
      errors++; $display("FAIL slave_out: bits %b frames %0d, required 11110110 0", got, fr);
    end
  endtask

  task automatic test_mode_switch();
    int fr;
    do_reset();
    send(4'b1010, 1'b0);
    ssp_dout = 1'b1; data_in = 1'b1;
    repeat (5) bit_step();
    ssp_dout = 1'b0;
    mod_type = 3'd1;
    @(negedge clk);
    checks++;
    if (dut.r_rx_sr !== 8'd0 || dut.r_tx_sr !== 4'd0) begin
      errors++; $display("FAIL switch_clear: rx %b tx %b, required 0 0", dut.r_rx_sr, dut.r_tx_sr);
    end
    checks++;
    if ({ssp_frame, ssp_din, data_out} !== 3'b000) begin
      errors++; $display("FAIL switch_outputs: got %b, required 000", {ssp_frame, ssp_din, data_out});
    end
    fr = 0;
    repeat (3) begin
      bit_step();
      fr += (ssp_frame === 1'b1) ? 1 : 0;
    end
    checks++;
    if (fr != 0) begin errors++; $display("FAIL switch_frame: %0d spurious frames, required 0", fr); end
    checks++;
    if (dut.r_state !== 2'd1 || dut.r_delay === 12'd0) begin
      errors++; $display("FAIL switch_timing: state %0d delay %0d, required 1 and nonzero", dut.r_state, dut.r_delay);
    end
    data_in = 1'b0;
  endtask

`ifdef RELAY_LOOPBACK_EN
  task automatic test_loopback();
    int n = 0;
    do_reset();
    mod_type = 3'd3;
    bit_step();
    send(4'b1010, 1'b0);
    while (dut.r_state !== 2'd2 && n < 10) begin bit_step(); n++; end
    checks++;
    if (dut.r_state !== 2'd2 || dut.r_delay < 16 || dut.r_delay > 96) begin
      errors++; $display("FAIL loopback: state %0d delay %0d, required 2 and 16..96", dut.r_state, dut.r_delay);
    end
  endtask
`else
  task automatic test_idle_mode();
    logic any;
    do_reset();
    mod_type = 3'd3; ssp_dout = 1'b1; data_in = 1'b1;
    any = 1'b0;
    repeat (4) begin
      bit_step();
      any = any | ssp_frame | ssp_din | data_out;
    end
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL idle_outputs: got %b, required 0", any); end
    ssp_dout = 1'b0; data_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_master_delay();
    test_timeout();
    test_slave();
    test_mode_switch();
`ifdef RELAY_LOOPBACK_EN
    test_loopback();
`else
    test_idle_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
